msrv32_machine_control: RTL and testbench

- Machine-mode trap/return sequencer for the 2-stage msrv32 core.
- Detects exceptions, enabled pending interrupts and MRET in stage 1, and steers PC source selection.
- Drives CSR trap side-effects (mcause, mepc, mstatus.MIE).
- Produces flush_out, which directly feeds the write-enable generator so that squashed instructions never write the integer or CSR files.

---
 rtl/msrv32_machine_control.sv | 205 ++++++++++++++++++++
 tb/tb_msrv32_machine_control.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: exception/interrupt/MRET detection, PC source and CSR strobes.
// Optional WFI wait state enabled by defining MSRV32_WFI_EN.
module msrv32_machine_control #(
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_cause_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out
);

    typedef enum logic [2:0] {
        StReset,
        StOperating,
        StTrapTaken,
        StTrapReturn
`ifdef MSRV32_WFI_EN
        , StWaitIrq
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] reset_cnt_q, reset_cnt_d;
    logic [3:0] cause_q, cause_d;
    logic       i_or_e_q, i_or_e_d;
    logic       mis_q, mis_d;

    logic       is_system, is_ecall, is_ebreak, is_mret;
    logic       exc, exc_mis;
    logic [3:0] exc_cause;
    logic       irq_ext, irq_sw, irq_tim, irq_pending, irq_take;
    logic [3:0] irq_cause;
    logic       trap;

    assign is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                       (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign is_ecall  = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign is_ebreak = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign is_mret   = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);
`ifdef MSRV32_WFI_EN
    logic is_wfi;
    assign is_wfi    = is_system && (funct7_in == 7'b0001000) && (rs2_addr_in == 5'b00101);
`endif

    always_comb begin
        exc       = 1'b1;
        exc_mis   = 1'b0;
        exc_cause = 4'd0;
        if (misaligned_instr_in) begin
            exc_cause = 4'd0;
            exc_mis   = 1'b1;
        end else if (illegal_instr_in) begin
            exc_cause = 4'd2;
        end else if (is_ebreak) begin
            exc_cause = 4'd3;
        end else if (is_ecall) begin
            exc_cause = 4'd11;
        end else if (misaligned_load_in) begin
            exc_cause = 4'd4;
            exc_mis   = 1'b1;
        end else if (misaligned_store_in) begin
            exc_cause = 4'd6;
            exc_mis   = 1'b1;
        end else begin
            exc = 1'b0;
        end
    end

    // Pending-and-enabled ignores mstatus.MIE so it can also serve as the WFI wake condition.
    assign irq_ext     = meie_in & meip_in;
    assign irq_sw      = msie_in & msip_in;
    assign irq_tim     = mtie_in & mtip_in;
    assign irq_pending = irq_ext | irq_sw | irq_tim;
    assign irq_cause   = irq_ext ? 4'd11 : (irq_sw ? 4'd3 : 4'd7);
    assign irq_take    = mie_in & irq_pending;
    assign trap        = exc | irq_take;

    always_comb begin
        state_d     = state_q;
        reset_cnt_d = reset_cnt_q;
        cause_d     = cause_q;
        i_or_e_d    = i_or_e_q;
        mis_d       = mis_q;
        unique case (state_q)
            StReset: begin
                reset_cnt_d = reset_cnt_q + 4'd1;
                if (reset_cnt_q == 4'(RESET_CYCLES - 1)) begin
                    state_d = StOperating;
                end
            end
            StOperating: begin
                if (trap) begin
                    state_d  = StTrapTaken;
                    cause_d  = exc ? exc_cause : irq_cause;
                    i_or_e_d = ~exc;
                    mis_d    = exc & exc_mis;
                end else if (is_mret) begin
                    state_d = StTrapReturn;
`ifdef MSRV32_WFI_EN
                end else if (is_wfi) begin
                    state_d = StWaitIrq;
`endif
                end
            end
            StTrapTaken:  state_d = StOperating;
            StTrapReturn: state_d = StOperating;
`ifdef MSRV32_WFI_EN
            StWaitIrq: begin
                if (irq_pending) begin
                    if (mie_in) begin
                        state_d  = StTrapTaken;
                        cause_d  = irq_cause;
                        i_or_e_d = 1'b1;
                        mis_d    = 1'b0;
                    end else begin
                        state_d = StOperating;
                    end
                end
            end
`endif
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q     <= StReset;
            reset_cnt_q <= 4'd0;
            cause_q     <= 4'd0;
            i_or_e_q    <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            reset_cnt_q <= reset_cnt_d;
            cause_q     <= cause_d;
            i_or_e_q    <= i_or_e_d;
            mis_q       <= mis_d;
        end
    end

    always_comb begin
        pc_src_out      = 2'b00;
        flush_out       = 1'b1;
        trap_taken_out  = 1'b0;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        unique case (state_q)
            StReset: ;
            StOperating: begin
                pc_src_out      = 2'b01;
                flush_out       = 1'b0;
                instret_inc_out = ~(trap | is_mret);
            end
            StTrapTaken: begin
                pc_src_out     = 2'b11;
                trap_taken_out = 1'b1;
                set_cause_out  = 1'b1;
                set_epc_out    = 1'b1;
                mie_clear_out  = 1'b1;
            end
            StTrapReturn: begin
                pc_src_out  = 2'b10;
                mie_set_out = 1'b1;
            end
`ifdef MSRV32_WFI_EN
            StWaitIrq: pc_src_out = 2'b01;
`endif
            default: ;
        endcase
    end

    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = mis_q;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed plus randomized bench for msrv32_machine_control against an instruction-word-level model.
module tb_msrv32_machine_control;

    localparam int unsigned RC = 2;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] WFI    = 32'h1050_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int PhOp = 0, PhTrap = 1, PhRet = 2, PhWait = 3;

    logic clk = 1'b0;
    logic rst;
    logic illegal, mis_instr, mis_load, mis_store;
    logic [31:0] instr;
    logic mie, meie, mtie, msie, meip, mtip, msip;
    logic [1:0] pc_src;
    logic flush, trap_taken, set_cause, i_or_e, set_epc, mie_clear, mie_set, instret_inc, mis_exc;
    logic [3:0] cause;

    int total = 0;
    int bad = 0;

    // Model state
    int reset_left;
    int phase;
    logic [3:0] m_cause;
    logic m_ie, m_mis;

    always #5 clk = ~clk;

    msrv32_machine_control #(.RESET_CYCLES(RC)) dut (
        .ms_riscv32_mp_clk_in    (clk),
        .ms_riscv32_mp_rst_in    (rst),
        .illegal_instr_in        (illegal),
        .misaligned_instr_in     (mis_instr),
        .misaligned_load_in      (mis_load),
        .misaligned_store_in     (mis_store),
        .opcode_6_to_2_in        (instr[6:2]),
        .funct3_in               (instr[14:12]),
        .funct7_in               (instr[31:25]),
        .rs1_addr_in             (instr[19:15]),
        .rs2_addr_in             (instr[24:20]),
        .rd_addr_in              (instr[11:7]),
        .mie_in                  (mie),
        .meie_in                 (meie),
        .mtie_in                 (mtie),
        .msie_in                 (msie),
        .meip_in                 (meip),
        .mtip_in                 (mtip),
        .msip_in                 (msip),
        .pc_src_out              (pc_src),
        .flush_out               (flush),
        .trap_taken_out          (trap_taken),
        .set_cause_out           (set_cause),
        .i_or_e_out              (i_or_e),
        .cause_out               (cause),
        .set_epc_out             (set_epc),
        .mie_clear_out           (mie_clear),
        .mie_set_out             (mie_set),
        .instret_inc_out         (instret_inc),
        .misaligned_exception_out(mis_exc)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_idle();
        illegal = 0; mis_instr = 0; mis_load = 0; mis_store = 0;
        instr = NOP;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    // Check the current cycle against the model, advance the model, move to next negedge.
    task automatic run_cycle();
        logic [1:0] e_pc;
        logic e_fl, e_tt, e_sc, e_epc, e_clr, e_set, e_inst;
        logic ex_flags[6];
        int unsigned ex_codes[6];
        int unsigned ecause, icause;
        bit exc, emis, irq_any, irq_t, is_mret;
        #1;
        ex_codes = '{0, 2, 3, 11, 4, 6};
        ex_flags = '{mis_instr, illegal, instr == EBREAK, instr == ECALL, mis_load, mis_store};
        exc = 0; ecause = 0; emis = 0;
        for (int i = 0; i < 6; i++) begin
            if (ex_flags[i] && !exc) begin
                exc = 1;
                ecause = ex_codes[i];
                emis = (ecause == 0) || (ecause == 4) || (ecause == 6);
            end
        end
        irq_any = (meie && meip) || (msie && msip) || (mtie && mtip);
        icause = (meie && meip) ? 11 : ((msie && msip) ? 3 : 7);
        irq_t = irq_any && mie;
        is_mret = (instr == MRET);

        e_pc = 2'b00; e_fl = 1; e_tt = 0; e_sc = 0; e_epc = 0; e_clr = 0; e_set = 0; e_inst = 0;
        if (reset_left == 0) begin
            case (phase)
                PhOp: begin
                    e_pc = 2'b01; e_fl = 0;
                    e_inst = !(exc || irq_t || is_mret);
                end
                PhTrap: begin
                    e_pc = 2'b11; e_tt = 1; e_sc = 1; e_epc = 1; e_clr = 1;
                end
                PhRet: begin
                    e_pc = 2'b10; e_set = 1;
                end
                default: e_pc = 2'b01;
            endcase
        end
        check("pc_src", 4'(pc_src), 4'(e_pc));
        check("flush", 4'(flush), 4'(e_fl));
        check("trap_taken", 4'(trap_taken), 4'(e_tt));
        check("set_cause", 4'(set_cause), 4'(e_sc));
        check("set_epc", 4'(set_epc), 4'(e_epc));
        check("mie_clear", 4'(mie_clear), 4'(e_clr));
        check("mie_set", 4'(mie_set), 4'(e_set));
        check("instret_inc", 4'(instret_inc), 4'(e_inst));
        check("cause", cause, m_cause);
        check("i_or_e", 4'(i_or_e), 4'(m_ie));
        check("misaligned", 4'(mis_exc), 4'(m_mis));

        if (reset_left > 0) begin
            reset_left--;
        end else begin
            case (phase)
                PhOp: begin
                    if (exc || irq_t) begin
                        phase = PhTrap;
                        m_cause = exc ? 4'(ecause) : 4'(icause);
                        m_ie = !exc;
                        m_mis = exc && emis;
                    end else if (is_mret) begin
                        phase = PhRet;
`ifdef MSRV32_WFI_EN
                    end else if (instr == WFI) begin
                        phase = PhWait;
`endif
                    end
                end
                PhWait: begin
                    if (irq_any) begin
                        if (mie) begin
                            phase = PhTrap;
                            m_cause = 4'(icause);
                            m_ie = 1;
                            m_mis = 0;
                        end else begin
                            phase = PhOp;
                        end
                    end
                end
                default: phase = PhOp;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        m_cause = 0; m_ie = 0; m_mis = 0; phase = PhOp;
        for (int i = 0; i < n; i++) begin
            reset_left = RC;
            run_cycle();
        end
        rst = 0;
        reset_left = RC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        do_reset(3);
        run_cycle(); run_cycle(); run_cycle();

        // ECALL trap and return to operating
        instr = ECALL; run_cycle();
        set_idle(); run_cycle(); run_cycle();

        // External interrupt beats timer; then illegal beats both
        mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1; run_cycle();
        set_idle(); run_cycle(); run_cycle();
        mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1; illegal = 1; run_cycle();
        set_idle(); run_cycle();

        // MRET, and MRET flagged illegal
        instr = MRET; run_cycle();
        set_idle(); run_cycle(); run_cycle();
        instr = MRET; illegal = 1; run_cycle();
        set_idle(); run_cycle();

        // Misaligned load vs store, misaligned store under EBREAK
        mis_load = 1; mis_store = 1; run_cycle();
        set_idle(); run_cycle();
        instr = EBREAK; mis_store = 1; run_cycle();
        set_idle(); run_cycle();

        // Reset asserted while in trap-taken state
        mis_instr = 1; run_cycle();
        set_idle();
        do_reset(1);
        run_cycle(); run_cycle(); run_cycle(); run_cycle();

`ifdef MSRV32_WFI_EN
        instr = WFI; run_cycle();
        set_idle(); run_cycle(); run_cycle();
        msie = 1; msip = 1; run_cycle();
        set_idle(); run_cycle();
        instr = WFI; run_cycle();
        set_idle(); mie = 1; run_cycle();
        msie = 1; msip = 1; run_cycle();
        set_idle(); run_cycle(); run_cycle();
`else
        instr = WFI; run_cycle();
        set_idle(); run_cycle();
`endif

        for (int n = 0; n < 500; n++) begin
            int unsigned r;
            set_idle();
            r = $urandom_range(0, 9);
            case (r)
                0: instr = ECALL;
                1: instr = EBREAK;
                2: instr = MRET;
                3: instr = WFI;
                4: instr = ECALL ^ (32'd1 << $urandom_range(2, 31));
                default: instr = {$urandom(), 2'b11} >> 0;
            endcase
            instr[1:0] = 2'b11;
            illegal   = ($urandom_range(0, 11) == 0);
            mis_instr = ($urandom_range(0, 11) == 0);
            mis_load  = ($urandom_range(0, 11) == 0);
            mis_store = ($urandom_range(0, 11) == 0);
            mie  = $urandom_range(0, 1) == 1;
            meie = $urandom_range(0, 1) == 1;
            mtie = $urandom_range(0, 1) == 1;
            msie = $urandom_range(0, 1) == 1;
            meip = ($urandom_range(0, 5) == 0);
            mtip = ($urandom_range(0, 5) == 0);
            msip = ($urandom_range(0, 5) == 0);
            if (n == 250) begin
                do_reset(2);
            end
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
